// File: rtl/bp_pkg.sv
// Shared definitions for the dynamic branch predictor: 2-bit counter
// encodings, saturating counter helpers and the index-width derivation.
package bp_pkg;

  // 2-bit saturating counter states; the MSB is the taken/not-taken prediction.
  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_e;

  // Count toward strongly-taken, holding at ST.
  function automatic logic [1:0] sat_inc2(input logic [1:0] c);
    return (c == ST) ? ST : c + 2'd1;
  endfunction

  // Count toward strongly-not-taken, holding at SNT.
  function automatic logic [1:0] sat_dec2(input logic [1:0] c);
    return (c == SNT) ? SNT : c - 2'd1;
  endfunction

  // Index width for a power-of-two entry count (ENTRIES >= 2).
  function automatic int idx_w_of(input int entries);
    return $clog2(entries);
  endfunction

endpackage

// File: rtl/bp_perf_counter.sv
// Saturating event counter: increments once per cycle while inc is high and
// sticks at all-ones instead of wrapping.
module bp_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Synchronous clear, then saturating increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters. IF looks up a predicted
// next PC combinationally; ID reports each resolved branch/jump, gets back a
// mispredict flag and redirect PC, and trains the table on the clock edge.
//
// Update handshake: upd_valid is a one-cycle qualifier with no back-pressure.
// The predictor always accepts; each high cycle is exactly one resolved
// instruction, and the upd_* fields are only meaningful while it is high.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int         ENTRIES  = 16,
  parameter logic [1:0] CTR_INIT = 2'b01,
  parameter int         CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      lk_pc,
  output logic [31:0]      lk_next_pc,
  output logic             lk_taken,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_is_jump,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic             upd_pred_taken,
  input  logic [31:0]      upd_pred_next_pc,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] perf_branches,
  output logic [CNT_W-1:0] perf_mispredicts
);

  localparam int IDX_W = idx_w_of(ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;

  // Table storage as plain register arrays so the read port is asynchronous.
  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;

  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic             resolved_taken;
  logic [31:0]      resolved_next_pc;

  logic             tbl_we;
  logic             tgt_we;
  logic [1:0]       ctr_nxt;

  // The predicted direction carried from IF is implied by upd_pred_next_pc.
  logic             unused_pred_taken;
  assign unused_pred_taken = upd_pred_taken;

  assign lk_idx  = lk_pc[IDX_W+1:2];
  assign lk_tag  = lk_pc[31:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[31:IDX_W+2];

  // IF lookup; the table contents are meaningless while reset is held.
  always_comb begin
    lk_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    lk_taken   = !reset && lk_hit && ctr_q[lk_idx][1];
    lk_next_pc = lk_taken ? target_q[lk_idx] : lk_pc + 32'd4;
  end

  // ID resolution: compare the path IF took against the actual next PC.
  always_comb begin
    resolved_taken   = upd_is_jump || upd_taken;
    resolved_next_pc = resolved_taken ? upd_target : upd_pc + 32'd4;
    mispredict       = 1'b0;
    redirect_pc      = 32'd0;
    if (upd_valid) begin
      redirect_pc = resolved_next_pc;
      mispredict  = (upd_pred_next_pc != resolved_next_pc);
    end
  end

  // Training decision: hits always retrain, misses allocate only when taken.
  always_comb begin
    upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    tbl_we  = upd_valid && !reset && (upd_hit || resolved_taken);
    tgt_we  = upd_valid && !reset && resolved_taken;
    ctr_nxt = WT;
    if (upd_is_jump) begin
      ctr_nxt = ST;
    end else if (upd_hit) begin
      ctr_nxt = upd_taken ? sat_inc2(ctr_q[upd_idx]) : sat_dec2(ctr_q[upd_idx]);
    end
  end

  // Valid bits and counters: cleared/initialised on reset, trained otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_INIT;
      end
    end else if (tbl_we) begin
      valid_q[upd_idx] <= 1'b1;
      ctr_q[upd_idx]   <= ctr_nxt;
    end
  end

  // Tag and target need no reset; they are only read behind a valid bit.
  // On a hit the tag rewrite is a no-op, on a miss it allocates.
  always_ff @(posedge clk) begin
    if (tgt_we) begin
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= upd_target;
    end
  end

  bp_perf_counter #(.CNT_W(CNT_W)) u_perf_branches (
    .clk   (clk),
    .reset (reset),
    .inc   (upd_valid),
    .count (perf_branches)
  );

  bp_perf_counter #(.CNT_W(CNT_W)) u_perf_mispredicts (
    .clk   (clk),
    .reset (reset),
    .inc   (mispredict),
    .count (perf_mispredicts)
  );

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a vector table walked one cycle per
// entry, followed by hand-written reset and counter-saturation sequences.
module tb_branch_predictor;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] lk_pc;
  logic [31:0] lk_next_pc;
  logic        lk_taken;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_is_jump;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_next_pc;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;

  // Narrow-counter instance for saturation.
  logic        reset2;
  logic        upd_valid2;
  logic [31:0] lk_next_pc2;
  logic        lk_taken2;
  logic        mispredict2;
  logic [31:0] redirect_pc2;
  logic [1:0]  perf_branches2;
  logic [1:0]  perf_mispredicts2;

  branch_predictor #(.ENTRIES(16), .CTR_INIT(2'b01), .CNT_W(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .lk_pc            (lk_pc),
    .lk_next_pc       (lk_next_pc),
    .lk_taken         (lk_taken),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_is_jump      (upd_is_jump),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_pred_taken   (upd_pred_taken),
    .upd_pred_next_pc (upd_pred_next_pc),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
  );

  branch_predictor #(.ENTRIES(16), .CTR_INIT(2'b01), .CNT_W(2)) dut2 (
    .clk              (clk),
    .reset            (reset2),
    .lk_pc            (32'h40),
    .lk_next_pc       (lk_next_pc2),
    .lk_taken         (lk_taken2),
    .upd_valid        (upd_valid2),
    .upd_pc           (32'h40),
    .upd_is_jump      (1'b0),
    .upd_taken        (1'b1),
    .upd_target       (32'h100),
    .upd_pred_taken   (1'b0),
    .upd_pred_next_pc (32'h0),
    .mispredict       (mispredict2),
    .redirect_pc      (redirect_pc2),
    .perf_branches    (perf_branches2),
    .perf_mispredicts (perf_mispredicts2)
  );

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance to just after the next rising edge; inputs change here and
  // outputs are sampled a few ns later, well before the following edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_idle();
    upd_valid        = 1'b0;
    upd_pc           = 32'h0;
    upd_is_jump      = 1'b0;
    upd_taken        = 1'b0;
    upd_target       = 32'h0;
    upd_pred_taken   = 1'b0;
    upd_pred_next_pc = 32'h0;
  endtask

  task automatic drive_upd(input logic [31:0] pc, input logic jmp, input logic tkn,
                           input logic [31:0] tgt, input logic [31:0] pnext);
    upd_valid        = 1'b1;
    upd_pc           = pc;
    upd_is_jump      = jmp;
    upd_taken        = tkn;
    upd_target       = tgt;
    upd_pred_next_pc = pnext;
    upd_pred_taken   = (pnext != pc + 32'd4);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] lk;
    logic        uv;
    logic [31:0] upc;
    logic        jmp;
    logic        tkn;
    logic [31:0] tgt;
    logic [31:0] pnext;
    logic        e_tk;
    logic [31:0] e_next;
    logic        e_mis;
    logic [31:0] e_red;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic [31:0] lk, input logic uv, input logic [31:0] upc,
                              input logic jmp, input logic tkn, input logic [31:0] tgt,
                              input logic [31:0] pnext, input logic e_tk, input logic [31:0] e_next,
                              input logic e_mis, input logic [31:0] e_red);
    vec_t v;
    v.lk = lk; v.uv = uv; v.upc = upc; v.jmp = jmp; v.tkn = tkn; v.tgt = tgt;
    v.pnext = pnext; v.e_tk = e_tk; v.e_next = e_next; v.e_mis = e_mis; v.e_red = e_red;
    return v;
  endfunction

  int exp_br;
  int exp_mp;

  initial begin
    //             lk            uv  upc     jmp tkn tgt     pnext         e_tk e_next       e_mis e_red
    vecs[0]  = mk(32'h40,       0, 32'h0,   0, 0, 32'h0,   32'h0,        0, 32'h44,       0, 32'h0);   // cold
    vecs[1]  = mk(32'h40,       1, 32'h40,  0, 1, 32'h100, 32'h44,       0, 32'h44,       1, 32'h100); // allocate
    vecs[2]  = mk(32'h40,       0, 32'h0,   0, 0, 32'h0,   32'h0,        1, 32'h100,      0, 32'h0);
    vecs[3]  = mk(32'hFFFFFFFC, 0, 32'h0,   0, 0, 32'h0,   32'h0,        0, 32'h0,        0, 32'h0);   // +4 wraps
    vecs[4]  = mk(32'h80,       0, 32'h0,   0, 0, 32'h0,   32'h0,        0, 32'h84,       0, 32'h0);   // alias miss
    vecs[5]  = mk(32'h40,       1, 32'h40,  0, 1, 32'h100, 32'h100,      1, 32'h100,      0, 32'h100); // ctr 2->3
    vecs[6]  = mk(32'h40,       1, 32'h40,  0, 0, 32'h100, 32'h100,      1, 32'h100,      1, 32'h44);  // 3->2
    vecs[7]  = mk(32'h40,       0, 32'h0,   0, 0, 32'h0,   32'h0,        1, 32'h100,      0, 32'h0);   // still taken
    vecs[8]  = mk(32'h40,       1, 32'h40,  0, 0, 32'h100, 32'h100,      1, 32'h100,      1, 32'h44);  // 2->1
    vecs[9]  = mk(32'h40,       0, 32'h0,   0, 0, 32'h0,   32'h0,        0, 32'h44,       0, 32'h0);
    vecs[10] = mk(32'h40,       1, 32'h40,  0, 0, 32'h100, 32'h44,       0, 32'h44,       0, 32'h44);  // 1->0
    vecs[11] = mk(32'h40,       1, 32'h40,  0, 0, 32'h100, 32'h44,       0, 32'h44,       0, 32'h44);  // hold 0
    vecs[12] = mk(32'h40,       1, 32'h40,  0, 1, 32'h100, 32'h44,       0, 32'h44,       1, 32'h100); // 0->1
    vecs[13] = mk(32'h40,       0, 32'h0,   0, 0, 32'h0,   32'h0,        0, 32'h44,       0, 32'h0);
    vecs[14] = mk(32'h80,       1, 32'h80,  0, 1, 32'h300, 32'h84,       0, 32'h84,       1, 32'h300); // evict 0x40
    vecs[15] = mk(32'h40,       0, 32'h0,   0, 0, 32'h0,   32'h0,        0, 32'h44,       0, 32'h0);
    vecs[16] = mk(32'h80,       0, 32'h0,   0, 0, 32'h0,   32'h0,        1, 32'h300,      0, 32'h0);
    vecs[17] = mk(32'h200,      1, 32'h200, 1, 0, 32'h400, 32'h204,      0, 32'h204,      1, 32'h400); // jump, same cycle
    vecs[18] = mk(32'h200,      0, 32'h0,   0, 0, 32'h0,   32'h0,        1, 32'h400,      0, 32'h0);
    vecs[19] = mk(32'h44,       1, 32'h44,  0, 0, 32'h500, 32'h48,       0, 32'h48,       0, 32'h48);  // miss, not taken
    vecs[20] = mk(32'h44,       0, 32'h0,   0, 0, 32'h0,   32'h0,        0, 32'h48,       0, 32'h0);   // no alloc
    vecs[21] = mk(32'h200,      1, 32'h200, 1, 0, 32'h600, 32'h400,      1, 32'h400,      1, 32'h600); // jump hit retarget
    vecs[22] = mk(32'h200,      0, 32'h0,   0, 0, 32'h0,   32'h0,        1, 32'h600,      0, 32'h0);

    // ---------------- reset ----------------
    reset      = 1'b1;
    reset2     = 1'b1;
    upd_valid2 = 1'b0;
    lk_pc      = 32'h40;
    drive_idle();
    tick();
    tick();
    #3;
    chk("reset_lk_taken", {31'd0, lk_taken}, 32'd0);
    chk("reset_lk_next_pc", lk_next_pc, 32'h44);
    chk("reset_perf_branches", perf_branches, 32'd0);
    reset = 1'b0;

    // ---------------- table walk ----------------
    for (int i = 0; i < NV; i++) exp_q.push_back(vecs[i].e_next);
    exp_br = 0;
    exp_mp = 0;
    for (int i = 0; i < NV; i++) begin
      tick();
      lk_pc = vecs[i].lk;
      if (vecs[i].uv) drive_upd(vecs[i].upc, vecs[i].jmp, vecs[i].tkn, vecs[i].tgt, vecs[i].pnext);
      else drive_idle();
      #3;
      chk($sformatf("v%0d_lk_next_pc", i), lk_next_pc, exp_q.pop_front());
      chk($sformatf("v%0d_lk_taken", i), {31'd0, lk_taken}, {31'd0, vecs[i].e_tk});
      chk($sformatf("v%0d_mispredict", i), {31'd0, mispredict}, {31'd0, vecs[i].e_mis});
      chk($sformatf("v%0d_redirect_pc", i), redirect_pc, vecs[i].e_red);
      if (vecs[i].uv) exp_br++;
      if (vecs[i].e_mis) exp_mp++;
    end
    tick();
    drive_idle();
    #3;
    chk("table_perf_branches", perf_branches, 32'(exp_br));
    chk("table_perf_mispredicts", perf_mispredicts, 32'(exp_mp));

    // ---------------- reset mid-run with an update pending ----------------
    tick();
    reset = 1'b1;
    drive_upd(32'h600, 1'b0, 1'b1, 32'h700, 32'h604);
    lk_pc = 32'h200;
    #3;
    chk("inreset_lk_next_pc", lk_next_pc, 32'h204);
    chk("inreset_mispredict", {31'd0, mispredict}, 32'd1);
    chk("inreset_redirect_pc", redirect_pc, 32'h700);
    tick();
    reset = 1'b0;
    drive_idle();
    lk_pc = 32'h40;
    #3;
    chk("postreset_perf_branches", perf_branches, 32'd0);
    chk("postreset_perf_mispredicts", perf_mispredicts, 32'd0);
    chk("postreset_lk_0x40", lk_next_pc, 32'h44);
    lk_pc = 32'h600;
    #1;
    chk("postreset_upd_dropped", lk_next_pc, 32'h604);
    lk_pc = 32'h200;
    #1;
    chk("postreset_history_gone", lk_next_pc, 32'h204);

    // ---------------- 5 updates, 2 mispredicting, idle gaps ----------------
    tick(); drive_upd(32'h40, 1'b0, 1'b1, 32'h100, 32'h44);  // miss, taken: mispredict
    tick(); drive_idle();
    tick(); drive_upd(32'h40, 1'b0, 1'b1, 32'h100, 32'h100); // correct
    tick(); drive_upd(32'h48, 1'b0, 1'b0, 32'h80,  32'h4C);  // correct
    tick(); drive_idle();
    tick(); drive_upd(32'h48, 1'b0, 1'b1, 32'h80,  32'h4C);  // mispredict
    tick(); drive_upd(32'h40, 1'b0, 1'b0, 32'h100, 32'h44);  // correct
    tick(); drive_idle();
    #3;
    chk("seq_perf_branches", perf_branches, 32'd5);
    chk("seq_perf_mispredicts", perf_mispredicts, 32'd2);

    // ---------------- CNT_W=2 saturation ----------------
    reset2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      upd_valid2 = 1'b1;
      tick();
      if (i == 2) begin
        #3;
        chk("narrow_after3_branches", {30'd0, perf_branches2}, 32'd3);
      end
    end
    upd_valid2 = 1'b0;
    #3;
    chk("narrow_sat_branches", {30'd0, perf_branches2}, 32'd3);
    chk("narrow_sat_mispredicts", {30'd0, perf_mispredicts2}, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
